// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the two-client RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Client handshake and RAM port bundle; slave = arbiter side, master = clients plus RAM.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic              c0_req,    c1_req;
    logic              c0_we,     c1_we;
    logic [ADDR_W-1:0] c0_addr,   c1_addr;
    logic [DATA_W-1:0] c0_wdata,  c1_wdata;
    logic              c0_lock,   c1_lock;
    logic              c0_gnt,    c1_gnt;
    logic              c0_rvalid, c1_rvalid;
    logic [DATA_W-1:0] c0_rdata,  c1_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_wradd;
    logic [ADDR_W-1:0] ram_rdadd;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  c0_req, c0_we, c0_addr, c0_wdata, c0_lock,
        input  c1_req, c1_we, c1_addr, c1_wdata, c1_lock,
        output c0_gnt, c0_rvalid, c0_rdata,
        output c1_gnt, c1_rvalid, c1_rdata,
        output ram_we, ram_wradd, ram_rdadd, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output c0_req, c0_we, c0_addr, c0_wdata, c0_lock,
        output c1_req, c1_we, c1_addr, c1_wdata, c1_lock,
        input  c0_gnt, c0_rvalid, c0_rdata,
        input  c1_gnt, c1_rvalid, c1_rdata,
        input  ram_we, ram_wradd, ram_rdadd, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/ram_arb_rr2.sv
// Two-input round-robin picker; last_q remembers the most recently granted client.
module ram_arb_rr2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    // Resets to client 1 so client 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (gnt[0]) begin
            last_q <= 1'b0;
        end else if (gnt[1]) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-client arbiter for a 64Kx8 single-clock RAM with one-cycle read return.
// Define RAM_ARB_LOCK_EN to build the locked-burst FSM (LOCK0/LOCK1, MAX_BURST).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);

    logic [1:0] req;
    logic [1:0] gnt;

`ifdef RAM_ARB_LOCK_EN
    arb_state_e state_q;
    logic [7:0] burst_q;
    logic [8:0] burst_inc;

    assign burst_inc = {1'b0, burst_q} + 9'd1;

    // While locked, the other client is hidden from the picker so it cannot win.
    always_comb begin
        req = {bus.c1_req, bus.c0_req};
        unique case (state_q)
            LOCK0:   req = {1'b0, bus.c0_req};
            LOCK1:   req = {bus.c1_req, 1'b0};
            default: req = {bus.c1_req, bus.c0_req};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            burst_q <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    burst_q <= 8'd0;
                    if (MAX_BURST > 1) begin
                        if (gnt[0] && bus.c0_lock) begin
                            state_q <= LOCK0;
                            burst_q <= 8'd1;
                        end else if (gnt[1] && bus.c1_lock) begin
                            state_q <= LOCK1;
                            burst_q <= 8'd1;
                        end
                    end
                end
                LOCK0: begin
                    if (!bus.c0_req || !bus.c0_lock || burst_inc >= MAX_BURST[8:0]) begin
                        state_q <= IDLE;
                        burst_q <= 8'd0;
                    end else begin
                        burst_q <= burst_inc[7:0];
                    end
                end
                LOCK1: begin
                    if (!bus.c1_req || !bus.c1_lock || burst_inc >= MAX_BURST[8:0]) begin
                        state_q <= IDLE;
                        burst_q <= 8'd0;
                    end else begin
                        burst_q <= burst_inc[7:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    burst_q <= 8'd0;
                end
            endcase
        end
    end
`else
    logic       unused_lock;
    logic [7:0] unused_max_burst;

    assign req              = {bus.c1_req, bus.c0_req};
    assign unused_lock      = bus.c0_lock ^ bus.c1_lock;
    assign unused_max_burst = 8'(MAX_BURST);
`endif

    ram_arb_rr2 u_rr2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign bus.c0_gnt = gnt[0];
    assign bus.c1_gnt = gnt[1];

    logic              mux_we;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wdata;

    always_comb begin
        mux_we    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        if (gnt[0]) begin
            mux_we    = bus.c0_we;
            mux_addr  = bus.c0_addr;
            mux_wdata = bus.c0_wdata;
        end else if (gnt[1]) begin
            mux_we    = bus.c1_we;
            mux_addr  = bus.c1_addr;
            mux_wdata = bus.c1_wdata;
        end
    end

    assign bus.ram_we    = mux_we;
    assign bus.ram_wradd = mux_addr;
    assign bus.ram_rdadd = mux_addr;
    assign bus.ram_wdata = mux_wdata;

    logic pending_q;
    logic owner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            owner_q   <= 1'b0;
        end else begin
            pending_q <= (|gnt) && !mux_we;
            owner_q   <= gnt[1];
        end
    end

    assign bus.c0_rvalid = pending_q && !owner_q;
    assign bus.c1_rvalid = pending_q && owner_q;
    // Gate rdata so both clients see zero outside a read return.
    assign bus.c0_rdata  = pending_q ? bus.ram_rdata : '0;
    assign bus.c1_rdata  = pending_q ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 64Kx8 RAM and a read-return scoreboard.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    typedef struct packed {
        logic       owner;
        logic [7:0] data;
    } rd_item_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rd_item_t   sb[$];
    logic [7:0] exp_mem [logic [15:0]];
    logic [7:0] mem [0:65535];
    logic [7:0] ram_q;

    ram_arbiter_if bus ();

    ram_arbiter #(
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_wradd] <= bus.ram_wdata;
        ram_q <= mem[bus.ram_rdadd];
    end
    assign bus.ram_rdata = ram_q;

    task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 8'h00;
    endfunction

    task automatic set0(input logic r, input logic w, input logic l, input logic [15:0] a,
                        input logic [7:0] d);
        bus.c0_req = r; bus.c0_we = w; bus.c0_lock = l; bus.c0_addr = a; bus.c0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l, input logic [15:0] a,
                        input logic [7:0] d);
        bus.c1_req = r; bus.c1_we = w; bus.c1_lock = l; bus.c1_addr = a; bus.c1_wdata = d;
    endtask

    // One clock: check read return, grants and RAM drive mid-cycle, then predict.
    task automatic cycle(input logic e0, input logic e1, input string tag);
        rd_item_t    it;
        logic        ew;
        logic [15:0] ea;
        logic [7:0]  ed;
        @(negedge clk);
        if (sb.size() > 0) begin
            it = sb.pop_front();
            chk(bus.c0_rvalid, !it.owner, {tag, "/rv0"});
            chk(bus.c1_rvalid, it.owner, {tag, "/rv1"});
            chk(bus.c0_rdata, it.data, {tag, "/rd0"});
            chk(bus.c1_rdata, it.data, {tag, "/rd1"});
        end else begin
            chk(bus.c0_rvalid, 1'b0, {tag, "/rv0"});
            chk(bus.c1_rvalid, 1'b0, {tag, "/rv1"});
        end
        chk(bus.c0_gnt, e0, {tag, "/gnt0"});
        chk(bus.c1_gnt, e1, {tag, "/gnt1"});
        ew = 1'b0; ea = '0; ed = '0;
        if (e0) begin
            ew = bus.c0_we; ea = bus.c0_addr; ed = bus.c0_wdata;
        end else if (e1) begin
            ew = bus.c1_we; ea = bus.c1_addr; ed = bus.c1_wdata;
        end
        chk(bus.ram_we, ew, {tag, "/ram_we"});
        chk(bus.ram_wradd, ea, {tag, "/ram_wradd"});
        chk(bus.ram_rdadd, ea, {tag, "/ram_rdadd"});
        chk(bus.ram_wdata, ew ? ed : 8'h00, {tag, "/ram_wdata"});
        if (e0 || e1) begin
            if (ew) exp_mem[ea] = ed;
            else sb.push_back('{owner: e1, data: model_rd(ea)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] pat;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        set0(0, 0, 0, 16'h0, 8'h0);
        set1(0, 0, 0, 16'h0, 8'h0);
        #12;
        chk(bus.c0_gnt, 1'b0, "reset/gnt0");
        chk(bus.c1_gnt, 1'b0, "reset/gnt1");
        chk(bus.c0_rvalid, 1'b0, "reset/rv0");
        chk(bus.c1_rvalid, 1'b0, "reset/rv1");
        chk(bus.c0_rdata, 8'h00, "reset/rd0");
        chk(bus.c1_rdata, 8'h00, "reset/rd1");
        chk(bus.ram_we, 1'b0, "reset/ram_we");
        @(negedge clk);
        rst_n = 1'b1;

        // c0 writes, c1 reads it back
        set0(1, 1, 0, 16'h1234, 8'hA5); cycle(1, 0, "t1_wr");
        set0(0, 0, 0, 16'h0, 8'h0);
        set1(1, 0, 0, 16'h1234, 8'h0); cycle(0, 1, "t1_rd");
        set1(0, 0, 0, 16'h0, 8'h0);    cycle(0, 0, "t1_ret");

        // preload, then contended back-to-back reads
        set0(1, 1, 0, 16'h0010, 8'h11); cycle(1, 0, "pre0");
        set0(0, 0, 0, 16'h0, 8'h0);
        set1(1, 1, 0, 16'h0020, 8'h22); cycle(0, 1, "pre1");
        set0(1, 0, 0, 16'h0010, 8'h0);
        set1(1, 0, 0, 16'h0020, 8'h0);
        for (int i = 0; i < 4; i++) cycle(i % 2 == 0, i % 2 == 1, $sformatf("t2_%0d", i));
        set0(0, 0, 0, 16'h0, 8'h0);
        set1(0, 0, 0, 16'h0, 8'h0);
        cycle(0, 0, "t2_drain");

        // top address write/read, then address 0 must be untouched
        set1(1, 1, 0, 16'hFFFF, 8'h3C); cycle(0, 1, "t6_wr");
        set1(1, 0, 0, 16'hFFFF, 8'h0);  cycle(0, 1, "t6_rd");
        set1(0, 0, 0, 16'h0, 8'h0);
        set0(1, 0, 0, 16'h0000, 8'h0);  cycle(1, 0, "t6_rd0");
        set0(0, 0, 0, 16'h0, 8'h0);     cycle(0, 0, "t6_drain");

        // reset while a read is in flight
        set1(1, 0, 0, 16'h1234, 8'h0); cycle(0, 1, "t5_rd");
        set1(0, 0, 0, 16'h0, 8'h0);
        chk(bus.c1_rvalid, 1'b1, "t5_pre/rv1");
        chk(bus.c1_rdata, 8'hA5, "t5_pre/rd1");
        rst_n = 1'b0;
        #1;
        chk(bus.c0_rvalid, 1'b0, "t5_rst/rv0");
        chk(bus.c1_rvalid, 1'b0, "t5_rst/rv1");
        chk(bus.c1_rdata, 8'h00, "t5_rst/rd1");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, "t5_idle0");
        cycle(0, 0, "t5_idle1");

        // c0 holds lock, c1 contends; last pointer is back at client 1 after reset
`ifdef RAM_ARB_LOCK_EN
        pat = 10'b1111011110;
`else
        pat = 10'b1010101010;
`endif
        set0(1, 0, 1, 16'h0010, 8'h0);
        set1(1, 0, 0, 16'h0020, 8'h0);
        for (int i = 0; i < 10; i++) cycle(pat[9-i], !pat[9-i], $sformatf("t3_%0d", i));
        set0(0, 0, 0, 16'h0, 8'h0);
        set1(0, 0, 0, 16'h0, 8'h0);
        cycle(0, 0, "t3_drain");
        cycle(0, 0, "t3_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
